// File: rtl/iir_pkg.sv
// Shared widths and round-half-up / saturate helpers for the IIR output drain.
package iir_pkg;

    localparam int unsigned IN_WIDTH_DEF  = 38;
    localparam int unsigned OUT_WIDTH_DEF = 13;
    localparam int unsigned CALC_W        = 64;
    localparam int unsigned SUM_W         = CALC_W + 1;

    // Round half up, then arithmetic shift; one guard bit so the offset cannot wrap.
    function automatic logic signed [SUM_W-1:0] round_half_up(
        input logic signed [CALC_W-1:0] x,
        input int unsigned              shift
    );
        logic signed [SUM_W-1:0] sum;
        sum = SUM_W'(x);
        if (shift > 0) begin
            sum = sum + (SUM_W'(1) <<< (shift - 1));
        end
        return sum >>> shift;
    endfunction

    function automatic logic signed [SUM_W-1:0] lim_hi(input int unsigned out_w);
        return (SUM_W'(1) <<< (out_w - 1)) - SUM_W'(1);
    endfunction

    function automatic logic signed [SUM_W-1:0] lim_lo(input int unsigned out_w);
        return -(SUM_W'(1) <<< (out_w - 1));
    endfunction

    function automatic logic signed [CALC_W-1:0] round_sat(
        input logic signed [CALC_W-1:0] x,
        input int unsigned              shift,
        input int unsigned              out_w
    );
        logic signed [SUM_W-1:0] q;
        q = round_half_up(x, shift);
        if (q > lim_hi(out_w)) begin
            q = lim_hi(out_w);
        end else if (q < lim_lo(out_w)) begin
            q = lim_lo(out_w);
        end
        return CALC_W'(q);
    endfunction

    function automatic logic round_clips(
        input logic signed [CALC_W-1:0] x,
        input int unsigned              shift,
        input int unsigned              out_w
    );
        logic signed [SUM_W-1:0] q;
        q = round_half_up(x, shift);
        return (q > lim_hi(out_w)) || (q < lim_lo(out_w));
    endfunction

endpackage

// File: rtl/iir_drain_fifo.sv
// Power-of-two FIFO with extra-MSB pointers; simultaneous push and pop always succeed.
module iir_drain_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
        end
    end

    // When full, the write slot is the head being popped; the read sees the old word.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/iir_out_drain.sv
// IIR result requantizer feeding a small output FIFO.
// Macro IIR_DRAIN_STATS_EN enables the sat/overflow/drop_cnt statistics registers.
module iir_out_drain
    import iir_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = IN_WIDTH_DEF,
    parameter int unsigned OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int unsigned SHIFT     = 14,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clken,
    input  logic [IN_WIDTH-1:0]  result,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sat,
    output logic                 overflow,
    output logic [7:0]           drop_cnt
);

    logic signed [CALC_W-1:0] result_ext;
    logic [OUT_WIDTH-1:0]     s1_data;
    logic                     s1_valid;
    logic                     full;
    logic                     empty;
    logic                     pop;
    logic                     push;

    assign result_ext = CALC_W'(signed'(result));

    // Stage 1: requantized sample and its valid, one cycle behind clken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= clken;
            if (clken) s1_data <= OUT_WIDTH'(round_sat(result_ext, SHIFT, OUT_WIDTH));
        end
    end

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign push      = s1_valid && (!full || pop);

    iir_drain_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OUT_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push),
        .pop   (pop),
        .wdata (s1_data),
        .rdata (out_data),
        .full  (full),
        .empty (empty)
    );

`ifdef IIR_DRAIN_STATS_EN
    logic drop;

    assign drop = s1_valid && full && !pop;

    // Sticky flags and a saturating drop counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat      <= 1'b0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (clken && round_clips(result_ext, SHIFT, OUT_WIDTH)) sat <= 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end
`else
    assign sat      = 1'b0;
    assign overflow = 1'b0;
    assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_iir_out_drain.sv
// Directed bench for iir_out_drain: rounding, saturation, overflow, full-rate streaming, reset.
module tb_iir_out_drain;

    localparam int unsigned IN_W  = 38;
    localparam int unsigned OUT_W = 13;
`ifdef IIR_DRAIN_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             clken;
    logic [IN_W-1:0]  result;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             sat;
    logic             overflow;
    logic [7:0]       drop_cnt;

    int total = 0;
    int bad   = 0;

    iir_out_drain #(
        .IN_WIDTH  (38),
        .OUT_WIDTH (13),
        .SHIFT     (14),
        .DEPTH     (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clken     (clken),
        .result    (result),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat       (sat),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        clken     = 1'b0;
        out_ready = 1'b0;
        result    = '0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        clken     = 1'b0;
        out_ready = 1'b0;
        result    = '0;
        step();
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
        total++; if (out_data !== 13'h0) begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
        total++; if (sat !== 1'b0) begin bad++; $display("FAIL reset_sat got=%0b want=0", sat); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b want=0", overflow); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", drop_cnt); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_rounding();
        longint           vin  [5];
        logic [OUT_W-1:0] vexp [5];
        bit               vsat [5];
        vin  = '{64'sd90112, -64'sd90112, -64'sd81920, 64'sd137438953471, -64'sd137438953472};
        vexp = '{13'h0006, 13'h1FFB, 13'h1FFB, 13'h0FFF, 13'h1000};
        vsat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            clken  = 1'b1;
            result = IN_W'(vin[i]);
            step();
            clken = 1'b0;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rnd_latency[%0d] valid got=%0b want=0", i, out_valid); end
            step();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rnd_valid[%0d] got=%0b want=1", i, out_valid); end
            total++; if (out_data !== vexp[i]) begin bad++; $display("FAIL rnd_data[%0d] got=%h want=%h", i, out_data, vexp[i]); end
            total++; if (sat !== (vsat[i] & STATS)) begin bad++; $display("FAIL rnd_sat[%0d] got=%0b want=%0b", i, sat, vsat[i] & STATS); end
            step();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rnd_popped[%0d] valid got=%0b want=0", i, out_valid); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            clken  = 1'b1;
            result = IN_W'(i * 16384);
            step();
        end
        clken = 1'b0;
        step();
        step();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%0b want=1", out_valid); end
        total++; if (out_data !== 13'd1) begin bad++; $display("FAIL ovf_head got=%0d want=1", out_data); end
        total++; if (drop_cnt !== (STATS ? 8'd2 : 8'd0)) begin bad++; $display("FAIL ovf_drop_cnt got=%0d want=%0d", drop_cnt, STATS ? 2 : 0); end
        total++; if (overflow !== STATS) begin bad++; $display("FAIL ovf_flag got=%0b want=%0b", overflow, STATS); end
        step();
        total++; if (out_data !== 13'd1) begin bad++; $display("FAIL ovf_hold got=%0d want=1", out_data); end
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ovf_drain_valid[%0d] got=%0b want=1", k, out_valid); end
            total++; if (out_data !== OUT_W'(k)) begin bad++; $display("FAIL ovf_drain_data[%0d] got=%0d want=%0d", k, out_data, k); end
            step();
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%0b want=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int expv;
        expv = 1;
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            clken  = 1'b1;
            result = IN_W'(i * 16384);
            if (i == 6) out_ready = 1'b1;
            if (out_valid && out_ready) begin
                total++; if (out_data !== OUT_W'(expv)) begin bad++; $display("FAIL b2b_data got=%0d want=%0d", out_data, expv); end
                expv++;
            end
            step();
        end
        clken = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid && out_ready) begin
                total++; if (out_data !== OUT_W'(expv)) begin bad++; $display("FAIL b2b_drain got=%0d want=%0d", out_data, expv); end
                expv++;
            end
            step();
        end
        total++; if (expv !== 17) begin bad++; $display("FAIL b2b_count got=%0d want=17", expv - 1); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL b2b_drop_cnt got=%0d want=0", drop_cnt); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_ovf got=%0b want=0", overflow); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%0b want=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            clken  = 1'b1;
            result = (i == 3) ? IN_W'(64'sd137438953471) : IN_W'(i * 16384);
            step();
        end
        clken = 1'b0;
        step();
        step();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_prefill_valid got=%0b want=1", out_valid); end
        total++; if (sat !== STATS) begin bad++; $display("FAIL mid_prefill_sat got=%0b want=%0b", sat, STATS); end
        reset = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid got=%0b want=0", out_valid); end
        total++; if (out_data !== 13'h0) begin bad++; $display("FAIL mid_async_data got=%h want=0", out_data); end
        total++; if (sat !== 1'b0) begin bad++; $display("FAIL mid_async_sat got=%0b want=0", sat); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_async_ovf got=%0b want=0", overflow); end
        #1;
        reset = 1'b1;
        step();
        clken  = 1'b1;
        result = IN_W'(7 * 16384);
        step();
        clken = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_latency got=%0b want=0", out_valid); end
        step();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_post_valid got=%0b want=1", out_valid); end
        total++; if (out_data !== 13'd7) begin bad++; $display("FAIL mid_post_data got=%0d want=7", out_data); end
        out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_alone got=%0b want=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iir_out_drain.md
IIR_OUT_DRAIN -- requirements
Module: iir_out_drain

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 38, filter result word width (signed).
REQ-002 SHALL have parameter OUT_WIDTH, default 13, requantized sample width (signed).
REQ-003 SHALL have parameter SHIFT, default 14, count of LSBs discarded by requantization.
REQ-004 SHALL have parameter DEPTH, default 4, output FIFO entries (power of two, >=2).
REQ-005 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port clken, input, 1, sample strobe, same cadence as the filter's clken.
REQ-008 SHALL have port result, input, IN_WIDTH, filter output word, sampled when clken=1.
REQ-009 SHALL have port out_data, output, OUT_WIDTH, FIFO head sample.
REQ-010 SHALL have port out_valid, output, 1, FIFO non-empty.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts out_data when out_valid=1.
REQ-012 SHALL have port sat, output, 1, sticky; set when any sample was saturated.
REQ-013 SHALL have port overflow, output, 1, sticky; set when any sample was dropped on full.
REQ-014 SHALL have port drop_cnt, output, 8, count of dropped samples.

Function
REQ-015 Stage 1 SHALL register round(result) on each edge with clken=1; stage-1 valid SHALL follow clken one cycle later.
REQ-016 Rounding SHALL be round-half-up: (result + 2^(SHIFT-1)) arithmetic-shifted right by SHIFT, computed in IN_WIDTH+1 bits, no wrap.
REQ-017 Rounded values above 2^(OUT_WIDTH-1)-1 or below -2^(OUT_WIDTH-1) SHALL clamp to those limits and set sat.
REQ-018 Stage-1 valid SHALL push into the FIFO on the next edge; latency clken edge to out_valid = 2 cycles with FIFO empty.
REQ-019 Pop SHALL occur on an edge with out_valid=1 and out_ready=1; out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 Push with FIFO full and no pop on the same edge SHALL drop the sample, set overflow, increment drop_cnt.
REQ-021 Push and pop on the same edge SHALL both succeed in every occupancy state, including full.
REQ-022 drop_cnt SHALL saturate at 255, no wrap.
REQ-023 Read/write pointers SHALL be log2(DEPTH)+1 bits; full/empty from MSB compare; wrap with no lost or duplicated entry.
REQ-024 clken deasserted SHALL leave the stage-1 register and FIFO unchanged except for pops.

Reset
REQ-025 reset=0 SHALL asynchronously clear stage-1 valid, FIFO pointers, sat, overflow, drop_cnt; out_valid=0, out_data=0.
REQ-026 Reset mid-operation SHALL discard all buffered samples; first post-reset output appears 2 cycles after the first clken.
REQ-027 Reset deassertion SHALL be synchronized externally; no internal synchronizer.

Configuration
REQ-028 Macro IIR_DRAIN_STATS_EN defined: sat, overflow, drop_cnt SHALL behave as REQ-017/020/022.
REQ-029 Macro undefined: sat, overflow, drop_cnt SHALL be tied to 0 and their registers absent; data path unchanged.

Structure
REQ-030 Shared package iir_pkg SHALL hold IN_WIDTH/OUT_WIDTH defaults and the round-and-saturate function.
REQ-031 FIFO SHALL be a separate sub-module iir_drain_fifo (DEPTH, WIDTH parameters, push/pop/full/empty).

Verification (SHIFT=14, OUT_WIDTH=13, DEPTH=4)
REQ-032 result=90112 (5.5 LSB), one clken -> out_data=6 two cycles later, sat=0.
REQ-033 result=-90112 -> out_data=-5 (0x1FFB); result=-81920 -> out_data=-5.
REQ-034 result=2^37-1 -> out_data=4095 (0x0FFF), sat=1; result=-2^37 -> out_data=-4096 (0x1000).
REQ-035 out_ready=0, six consecutive clken samples 1..6 -> FIFO holds 1..4, drop_cnt=2, overflow=1; release ready -> 1,2,3,4 in order.
REQ-036 FIFO full, out_ready=1 with clken every cycle -> no drops, drop_cnt unchanged, order preserved across pointer wrap.
REQ-037 reset pulsed low with 3 entries buffered -> out_valid=0 immediately, sticky flags cleared, next sample output alone.
